// File: rtl/lag_stats_pkg.sv
// Shared types and constants for the lag tester statistics stage.
package lag_stats_pkg;

  typedef enum logic [2:0] {IDLE, B2D, UPDATE, D2B, PUBLISH} state_t;

  localparam int unsigned BCD_DIGITS = 6;
  localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;
  localparam int unsigned BIN_WIDTH  = 20;
  localparam int unsigned B2D_CYCLES = 6;
  localparam int unsigned D2B_CYCLES = 20;

  function automatic logic bcd_ok(input logic [BCD_WIDTH-1:0] v);
    bcd_ok = 1'b1;
    for (int unsigned d = 0; d < BCD_DIGITS; d++)
      if (v[d*4 +: 4] > 4'd9) bcd_ok = 1'b0;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: 20-bit binary to 6-digit BCD, start/done handshake.
module bin2bcd_serial
  import lag_stats_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 abort,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 done,
  output logic [BCD_WIDTH-1:0] bcd
);

  logic [BIN_WIDTH-1:0] bin_sr;
  logic [BCD_WIDTH-1:0] adj;
  logic [4:0]           shifts_left;
  logic                 active;

  always_comb begin
    adj = bcd;
    for (int unsigned d = 0; d < BCD_DIGITS; d++)
      if (bcd[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || abort) begin
      bin_sr      <= '0;
      bcd         <= '0;
      shifts_left <= '0;
      active      <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // First shift folded into the load: add-3 is a no-op on an all-zero register.
        bcd         <= {{(BCD_WIDTH-1){1'b0}}, bin[BIN_WIDTH-1]};
        bin_sr      <= bin << 1;
        shifts_left <= 5'(D2B_CYCLES - 1);
        active      <= 1'b1;
      end else if (active) begin
        bcd         <= {adj[BCD_WIDTH-2:0], bin_sr[BIN_WIDTH-1]};
        bin_sr      <= bin_sr << 1;
        shifts_left <= shifts_left - 5'd1;
        if (shifts_left == 5'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lag_stats.sv
// Last/min/max/sliding-mean statistics over BCD latency samples, results in BCD.
module lag_stats
  import lag_stats_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic [BCD_WIDTH-1:0] sample_bcd,
  input  logic                 clear,
  output logic                 busy,
  output logic                 stats_valid,
  output logic [BCD_WIDTH-1:0] last_bcd,
  output logic [BCD_WIDTH-1:0] min_bcd,
  output logic [BCD_WIDTH-1:0] max_bcd,
  output logic [BCD_WIDTH-1:0] avg_bcd,
  output logic                 avg_valid,
  output logic [7:0]           sample_count,
  output logic                 overrun,
  output logic                 bad_digit
);

  localparam int unsigned WIN   = 1 << WINDOW_LOG2;
  localparam int unsigned SUM_W = BIN_WIDTH + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] FILL_FULL = (WINDOW_LOG2+1)'(WIN);

  state_t                 state;
  logic [BCD_WIDTH-1:0]   sample_r, digit_sr;
  logic [BIN_WIDTH-1:0]   acc, acc_next;
  logic [2:0]             digit_cnt;
  logic [BIN_WIDTH-1:0]   window [WIN];
  logic [WINDOW_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]       sum, sum_next;
  logic [WINDOW_LOG2:0]   fill;
  logic [7:0]             count;
  logic [BCD_WIDTH-1:0]   last_r, min_r, max_r;
  logic                   d2b_start, d2b_done;
  logic [BIN_WIDTH-1:0]   d2b_bin;
  logic [BCD_WIDTH-1:0]   d2b_bcd;

  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + BIN_WIDTH'(digit_sr[BCD_WIDTH-1 -: 4]);
    sum_next  = sum + SUM_W'(acc) - SUM_W'(window[wr_ptr]);
    d2b_bin   = sum_next[SUM_W-1:WINDOW_LOG2];
    d2b_start = (state == UPDATE);
  end

  bin2bcd_serial u_d2b (
    .clock   (clock),
    .reset_n (reset_n),
    .abort   (clear),
    .start   (d2b_start),
    .bin     (d2b_bin),
    .done    (d2b_done),
    .bcd     (d2b_bcd)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state        <= IDLE;
      sample_r     <= '0;
      digit_sr     <= '0;
      acc          <= '0;
      digit_cnt    <= '0;
      for (int unsigned i = 0; i < WIN; i++) window[i] <= '0;
      wr_ptr       <= '0;
      sum          <= '0;
      fill         <= '0;
      count        <= '0;
      last_r       <= '0;
      min_r        <= '0;
      max_r        <= '0;
      busy         <= 1'b0;
      stats_valid  <= 1'b0;
      last_bcd     <= '0;
      min_bcd      <= '0;
      max_bcd      <= '0;
      avg_bcd      <= '0;
      avg_valid    <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
      bad_digit    <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_valid) begin
            if (bcd_ok(sample_bcd)) begin
              sample_r  <= sample_bcd;
              digit_sr  <= sample_bcd;
              acc       <= '0;
              digit_cnt <= '0;
              busy      <= 1'b1;
              state     <= B2D;
            end else begin
              bad_digit <= 1'b1;
            end
          end
        end

        B2D: begin
          acc       <= acc_next;
          digit_sr  <= digit_sr << 4;
          digit_cnt <= digit_cnt + 3'd1;
          if (digit_cnt == 3'(B2D_CYCLES - 1)) state <= UPDATE;
        end

        UPDATE: begin
          sum            <= sum_next;
          window[wr_ptr] <= acc;
          wr_ptr         <= wr_ptr + 1'b1;
          last_r         <= sample_r;
          // BCD digit order matches numeric order, so compare without conversion.
          if (count == 8'd0 || sample_r < min_r) min_r <= sample_r;
          if (count == 8'd0 || sample_r > max_r) max_r <= sample_r;
          if (count != 8'hFF) count <= count + 8'd1;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
          state <= D2B;
        end

        D2B: begin
          if (d2b_done) state <= PUBLISH;
        end

        PUBLISH: begin
          last_bcd     <= last_r;
          min_bcd      <= min_r;
          max_bcd      <= max_r;
          sample_count <= count;
          avg_valid    <= (fill == FILL_FULL);
          avg_bcd      <= (fill == FILL_FULL) ? d2b_bcd : '0;
          stats_valid  <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lag_stats.sv
// Self-checking bench for lag_stats: queue-based reference model plus directed literal checks.
module tb_lag_stats;

  localparam int WL      = 3;
  localparam int WIN     = 1 << WL;
  localparam int LATENCY = 28;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_bcd = '0;
  logic        clear = 1'b0;
  logic        busy, stats_valid, avg_valid, overrun, bad_digit;
  logic [23:0] last_bcd, min_bcd, max_bcd, avg_bcd;
  logic [7:0]  sample_count;

  lag_stats #(.WINDOW_LOG2(WL)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_bcd   (sample_bcd),
    .clear        (clear),
    .busy         (busy),
    .stats_valid  (stats_valid),
    .last_bcd     (last_bcd),
    .min_bcd      (min_bcd),
    .max_bcd      (max_bcd),
    .avg_bcd      (avg_bcd),
    .avg_valid    (avg_valid),
    .sample_count (sample_count),
    .overrun      (overrun),
    .bad_digit    (bad_digit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [23:0] v);
    int r = 0;
    for (int d = 5; d >= 0; d--) r = r * 10 + int'(v[d*4 +: 4]);
    return r;
  endfunction

  function automatic logic [23:0] int2bcd(input int v);
    logic [23:0] r = '0;
    int x = v;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [23:0] v);
    for (int d = 0; d < 6; d++) if (v[d*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: every accepted sample since the last clear, judged by value.
  bit          armed = 1'b0;
  int          edge_n = 0;
  bit          pend = 1'b0;
  int          pend_val, publish_at;
  int          win_q[$];
  int          n_acc, all_min, all_max;
  logic [23:0] exp_last = '0, exp_min = '0, exp_max = '0, exp_avg = '0;
  logic        exp_avg_valid = 1'b0, exp_sv = 1'b0, exp_busy = 1'b0;
  logic        exp_overrun = 1'b0, exp_bad = 1'b0;
  int          exp_count = 0;

  always @(posedge clock) begin
    edge_n++;
    exp_sv = 1'b0;
    if (!reset_n || clear) begin
      armed = 1'b1;
      pend = 1'b0;
      win_q.delete();
      n_acc = 0;
      exp_last = '0; exp_min = '0; exp_max = '0; exp_avg = '0;
      exp_avg_valid = 1'b0; exp_overrun = 1'b0; exp_bad = 1'b0;
      exp_count = 0;
    end else begin
      if (sample_valid) begin
        if (pend) exp_overrun = 1'b1;
        else if (!digits_ok(sample_bcd)) exp_bad = 1'b1;
        else begin
          pend = 1'b1;
          pend_val = bcd2int(sample_bcd);
          publish_at = edge_n + LATENCY;
        end
      end
      if (pend && edge_n == publish_at) begin
        int s;
        pend = 1'b0;
        n_acc++;
        win_q.push_back(pend_val);
        if (win_q.size() > WIN) void'(win_q.pop_front());
        if (n_acc == 1) begin all_min = pend_val; all_max = pend_val; end
        else begin
          if (pend_val < all_min) all_min = pend_val;
          if (pend_val > all_max) all_max = pend_val;
        end
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        exp_last      = int2bcd(pend_val);
        exp_min       = int2bcd(all_min);
        exp_max       = int2bcd(all_max);
        exp_count     = (n_acc > 255) ? 255 : n_acc;
        exp_avg_valid = (win_q.size() == WIN);
        exp_avg       = exp_avg_valid ? int2bcd(s / WIN) : '0;
        exp_sv        = 1'b1;
      end
    end
    exp_busy = pend;
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("busy",         32'(busy),         32'(exp_busy));
      chk("stats_valid",  32'(stats_valid),  32'(exp_sv));
      chk("last_bcd",     32'(last_bcd),     32'(exp_last));
      chk("min_bcd",      32'(min_bcd),      32'(exp_min));
      chk("max_bcd",      32'(max_bcd),      32'(exp_max));
      chk("avg_bcd",      32'(avg_bcd),      32'(exp_avg));
      chk("avg_valid",    32'(avg_valid),    32'(exp_avg_valid));
      chk("sample_count", 32'(sample_count), 32'(exp_count));
      chk("overrun",      32'(overrun),      32'(exp_overrun));
      chk("bad_digit",    32'(bad_digit),    32'(exp_bad));
    end
  end

  task automatic drive(input logic [23:0] v);
    sample_bcd   = v;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wait_stats(output int lat);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clock);
      if (stats_valid) lat = k;
    end
  endtask

  task automatic send(input logic [23:0] v);
    int lat;
    drive(v);
    wait_stats(lat);
    chk("latency", 32'(lat), 32'(LATENCY));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clock);
    chk("reset_count", 32'(sample_count), 32'd0);
    chk("reset_busy",  32'(busy),         32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    send(24'h000123);
    repeat (5) @(negedge clock);
    send(24'h000456);
    chk("t1_last",      32'(last_bcd),     32'h000456);
    chk("t1_min",       32'(min_bcd),      32'h000123);
    chk("t1_max",       32'(max_bcd),      32'h000456);
    chk("t1_count",     32'(sample_count), 32'd2);
    chk("t1_avg_valid", 32'(avg_valid),    32'd0);
    chk("t1_avg",       32'(avg_bcd),      32'h000000);

    do_clear();
    for (int i = 1; i <= 8; i++) send(int2bcd(i * 100));
    chk("t2_avg",       32'(avg_bcd),   32'h000450);
    chk("t2_avg_valid", 32'(avg_valid), 32'd1);
    send(24'h000900);
    chk("t2_avg9", 32'(avg_bcd), 32'h000550);
    chk("t2_min9", 32'(min_bcd), 32'h000100);
    chk("t2_max9", 32'(max_bcd), 32'h000900);

    do_clear();
    for (int i = 0; i < 8; i++) send(24'h999999);
    chk("t3_avg", 32'(avg_bcd), 32'h999999);
    chk("t3_min", 32'(min_bcd), 32'h999999);
    chk("t3_max", 32'(max_bcd), 32'h999999);

    drive(24'h00A123);
    repeat (35) @(negedge clock);
    chk("t4_bad",   32'(bad_digit),    32'd1);
    chk("t4_count", 32'(sample_count), 32'd8);
    drive(24'h000321);
    repeat (4) @(negedge clock);
    drive(24'h000654);
    wait_stats(lat);
    chk("t4_stats_seen", 32'(lat > 0), 32'd1);
    chk("t4_overrun", 32'(overrun),      32'd1);
    chk("t4_count2",  32'(sample_count), 32'd9);
    chk("t4_last",    32'(last_bcd),     32'h000321);
    chk("t4_avg",     32'(avg_bcd),      32'h875039);

    drive(24'h000300);
    repeat (9) @(negedge clock);
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample_bcd   = 24'h000555;
    @(negedge clock);
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("t5_busy",    32'(busy),         32'd0);
    chk("t5_last",    32'(last_bcd),     32'd0);
    chk("t5_count",   32'(sample_count), 32'd0);
    chk("t5_overrun", 32'(overrun),      32'd0);
    chk("t5_bad",     32'(bad_digit),    32'd0);
    repeat (30) @(negedge clock);
    send(24'h000777);
    chk("t5_min",    32'(min_bcd),      32'h000777);
    chk("t5_max",    32'(max_bcd),      32'h000777);
    chk("t5_last2",  32'(last_bcd),     32'h000777);
    chk("t5_count2", 32'(sample_count), 32'd1);

    for (int i = 0; i < 300; i++) send(int2bcd((i * 7919 + 13) % 1000000));
    chk("t6_count_sat", 32'(sample_count), 32'd255);

    drive(24'h000042);
    repeat (12) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("t7_busy",  32'(busy),         32'd0);
    chk("t7_count", 32'(sample_count), 32'd0);
    repeat (35) @(negedge clock);
    send(24'h000050);
    chk("t7_last", 32'(last_bcd), 32'h000050);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
